// File: rtl/serial_pkg.sv
// serial_pkg: line FSM state encoding and idle line level shared by the serial line blocks
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} tx_state_t;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/data(MSB-first)/stop serialiser on tx_a with a per-frame 0->1 transition count
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_a,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] pattern_cnt
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    tx_state_t        r_state, w_next;
    logic [WIDTH-1:0] r_sr, w_sr_next;
    logic [BIT_W-1:0] r_bit;
    logic [GAP_W-1:0] r_gap;
    logic [CNT_W-1:0] r_run, r_pcnt, w_run_next;
    logic             r_tx, r_done, w_tx_next, w_accept, w_rise;

    assign w_accept = in_valid && (r_state == IDLE);

    // Line level is computed from the next state so tx_a itself is a flop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? START : IDLE;
            START:   w_next = DATA;
            DATA:    w_next = (r_bit == BIT_W'(WIDTH - 1)) ? STOP : DATA;
            STOP:    w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     w_next = (r_gap == GAP_W'(GAP_CYCLES - 1)) ? IDLE : GAP;
            default: w_next = IDLE;
        endcase
        w_sr_next  = w_accept ? in_data : (r_state == DATA) ? r_sr << 1 : r_sr;
        w_tx_next  = (w_next == START) ? 1'b0 : (w_next == DATA) ? w_sr_next[WIDTH-1] : IDLE_LEVEL;
        w_rise     = !r_tx && w_tx_next;
        w_run_next = w_accept ? '0 : r_run + CNT_W'(w_rise);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tx    <= IDLE_LEVEL;
            r_done  <= 1'b0;
            r_pcnt  <= '0;
            r_run   <= '0;
            r_sr    <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_next;
            r_done  <= (w_next == STOP);
            r_pcnt  <= (w_next == STOP) ? w_run_next : r_pcnt;
            r_run   <= w_run_next;
            r_sr    <= w_sr_next;
            r_bit   <= (r_state == DATA) ? r_bit + BIT_W'(1) : '0;
            r_gap   <= (r_state == GAP) ? r_gap + GAP_W'(1) : '0;
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign tx_a        = r_tx;
    assign frame_done  = r_done;
    assign pattern_cnt = r_pcnt;
endmodule
